// File: rtl/crb_locality_arbiter_pkg.sv
// Shared definitions for the CRB locality arbiter.
//   state_t  : arbiter FSM state encoding
//   LOC_NONE : active_locality value when no locality owns the CRB
package crb_locality_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        OWNED = 3'd2,
        SEND  = 3'd3,
        BUSY  = 3'd4,
        DRAIN = 3'd5
    } state_t;

    localparam logic [7:0] LOC_NONE = 8'hFF;

endpackage

// File: rtl/crb_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   rr_last : index of the most recently served requester
//   valid   : at least one request is pending
//   idx     : first requester found scanning rr_last+1, rr_last+2, ... (mod N)
module crb_rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    input  logic [7:0]   rr_last,
    output logic         valid,
    output logic [7:0]   idx
);

    int           pos;
    logic [N-1:0] sh;

    always_comb begin
        valid = 1'b0;
        idx   = 8'd0;
        pos   = 0;
        sh    = '0;
        // k = N lands back on rr_last itself, so it is considered last
        for (int k = 1; k <= N; k++) begin
            pos = (int'(rr_last) + k) % N;
            sh  = req >> pos;
            if (!valid && sh[0]) begin
                valid = 1'b1;
                idx   = 8'(pos);
            end
        end
    end

endmodule

// File: rtl/crb_locality_arbiter.sv
// Arbitrates the single CRB command/response datapath between TPM localities.
//   clock, reset     : system clock, async active-high reset
//   req_access       : per-locality level request for ownership
//   relinquish       : per-locality pulse, owner gives up the CRB
//   start / cancel   : per-locality pulses, launch / abort the owner's command
//   rsp_done         : CRB engine pulse, response complete
//   loc_granted      : one-hot owner, active_locality : owner index (FF = none)
//   crb_cmd_send / crb_cmd_abort : pulses to the CRB engine
//   busy             : a command is outstanding
//   rsp_ready        : pulse to owner on normal completion
//   timeout_err      : pulse on watchdog expiry
module crb_locality_arbiter
    import crb_locality_arbiter_pkg::*;
#(
    parameter int NUM_LOC = 5,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_LOC-1:0] req_access,
    input  logic [NUM_LOC-1:0] relinquish,
    input  logic [NUM_LOC-1:0] start,
    input  logic [NUM_LOC-1:0] cancel,
    input  logic               rsp_done,
    output logic [NUM_LOC-1:0] loc_granted,
    output logic [7:0]         active_locality,
    output logic               crb_cmd_send,
    output logic               crb_cmd_abort,
    output logic               busy,
    output logic [NUM_LOC-1:0] rsp_ready,
    output logic               timeout_err
);

    state_t             state;
    logic [7:0]         owner;
    logic [7:0]         rr_last;
    logic [TW-1:0]      wd;
    logic               rel_pend;
    logic               pick_valid;
    logic [7:0]         pick_idx;
    logic [NUM_LOC-1:0] own_mask;
    logic               rel_hit, start_hit, cancel_hit, wd_exp;

    crb_rr_pick #(.N(NUM_LOC)) u_pick (
        .req     (req_access),
        .rr_last (rr_last),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Only the owner's control pulses are honoured; everyone else is masked.
    assign own_mask   = NUM_LOC'(1) << owner;
    assign rel_hit    = |(relinquish & own_mask);
    assign start_hit  = |(start & own_mask);
    assign cancel_hit = |(cancel & own_mask);
    assign wd_exp     = (wd == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= 8'd0;
            rr_last         <= 8'(NUM_LOC - 1);
            wd              <= '0;
            rel_pend        <= 1'b0;
            loc_granted     <= '0;
            active_locality <= LOC_NONE;
            crb_cmd_send    <= 1'b0;
            crb_cmd_abort   <= 1'b0;
            busy            <= 1'b0;
            rsp_ready       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            crb_cmd_send  <= 1'b0;
            crb_cmd_abort <= 1'b0;
            rsp_ready     <= '0;
            timeout_err   <= 1'b0;

            // Saturating watchdog, running only while a command is outstanding
            if ((state == BUSY || state == DRAIN) && wd != '1)
                wd <= wd + TW'(1);

            // A relinquish while a command is in flight is remembered and
            // applied once the datapath is back in OWNED.
            if ((state == SEND || state == BUSY || state == DRAIN) && rel_hit)
                rel_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    loc_granted     <= own_mask;
                    active_locality <= owner;
                    state           <= OWNED;
                end
                OWNED: begin
                    if (rel_hit || rel_pend) begin
                        loc_granted     <= '0;
                        active_locality <= LOC_NONE;
                        rr_last         <= owner;
                        rel_pend        <= 1'b0;
                        state           <= IDLE;
                    end else if (start_hit) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    crb_cmd_send <= 1'b1;
                    busy         <= 1'b1;
                    wd           <= '0;
                    state        <= BUSY;
                end
                BUSY: begin
                    if (rsp_done) begin
                        rsp_ready <= own_mask;
                        busy      <= 1'b0;
                        state     <= OWNED;
                    end else if (cancel_hit) begin
                        crb_cmd_abort <= 1'b1;
                        wd            <= '0;
                        state         <= DRAIN;
                    end else if (wd_exp) begin
                        crb_cmd_abort <= 1'b1;
                        timeout_err   <= 1'b1;
                        wd            <= '0;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Give the engine one more watchdog period to settle
                    if (rsp_done || wd_exp) begin
                        busy  <= 1'b0;
                        state <= OWNED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crb_locality_arbiter.sv
// Self-checking bench for crb_locality_arbiter (NUM_LOC=5, TIMEOUT=16).
// Each step drives one cycle of inputs, queues the expected outputs, and
// compares them after the following rising edge.
module tb_crb_locality_arbiter;
    import crb_locality_arbiter_pkg::*;

    localparam int N   = 5;
    localparam int TO  = 16;
    localparam int TWB = 5;
    localparam int DLY = 12;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req_access = '0, relinquish = '0, start = '0, cancel = '0;
    logic         rsp_done = 1'b0;
    logic [N-1:0] loc_granted, rsp_ready;
    logic [7:0]   active_locality;
    logic         crb_cmd_send, crb_cmd_abort, busy, timeout_err;

    crb_locality_arbiter #(.NUM_LOC(N), .TIMEOUT(TO), .TW(TWB)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_access      (req_access),
        .relinquish      (relinquish),
        .start           (start),
        .cancel          (cancel),
        .rsp_done        (rsp_done),
        .loc_granted     (loc_granted),
        .active_locality (active_locality),
        .crb_cmd_send    (crb_cmd_send),
        .crb_cmd_abort   (crb_cmd_abort),
        .busy            (busy),
        .rsp_ready       (rsp_ready),
        .timeout_err     (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] req, rel, st, can;
        logic         done;
    } in_t;

    typedef struct packed {
        logic [N-1:0] g;
        logic [7:0]   a;
        logic         send, abort, bsy;
        logic [N-1:0] rdy;
        logic         to;
    } out_t;

    typedef struct {
        string name;
        in_t   vi;
        out_t  vo;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    out_t   exp_q[$];
    string  nm_q[$];
    vec_t   tbl[14];

    localparam logic [N-1:0] Z  = '0;
    localparam logic [N-1:0] M0 = 5'b00001;
    localparam logic [N-1:0] M1 = 5'b00010;

    function automatic in_t mi(logic [N-1:0] req, logic [N-1:0] rel,
                               logic [N-1:0] st, logic [N-1:0] can, logic done);
        in_t v;
        v.req = req; v.rel = rel; v.st = st; v.can = can; v.done = done;
        return v;
    endfunction

    function automatic out_t mo(logic [N-1:0] g, logic [7:0] a, logic send,
                                logic abort, logic bsy, logic [N-1:0] rdy, logic to);
        out_t v;
        v.g = g; v.a = a; v.send = send; v.abort = abort; v.bsy = bsy;
        v.rdy = rdy; v.to = to;
        return v;
    endfunction

    function automatic vec_t mv(string name, in_t vi, out_t vo);
        vec_t v;
        v.name = name; v.vi = vi; v.vo = vo;
        return v;
    endfunction

    task automatic check(string name, out_t e);
        out_t a;
        a = out_t'({loc_granted, active_locality, crb_cmd_send, crb_cmd_abort,
                    busy, rsp_ready, timeout_err});
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got g=%b a=%h send=%b abort=%b busy=%b rdy=%b to=%b, expected g=%b a=%h send=%b abort=%b busy=%b rdy=%b to=%b",
                     name, a.g, a.a, a.send, a.abort, a.bsy, a.rdy, a.to,
                     e.g, e.a, e.send, e.abort, e.bsy, e.rdy, e.to);
        end
    endtask

    task automatic step(string name, in_t vi, out_t ve);
        req_access = vi.req;
        relinquish = vi.rel;
        start      = vi.st;
        cancel     = vi.can;
        rsp_done   = vi.done;
        exp_q.push_back(ve);
        nm_q.push_back(name);
        @(posedge clock);
        #1;
        check(nm_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        in_t  NOIN;
        out_t NONE, OW1, BZ1, RDY1;
        NOIN = mi(Z, Z, Z, Z, 1'b0);
        NONE = mo(Z, LOC_NONE, 1'b0, 1'b0, 1'b0, Z, 1'b0);
        OW1  = mo(M1, 8'd1, 1'b0, 1'b0, 1'b0, Z, 1'b0);
        BZ1  = mo(M1, 8'd1, 1'b0, 1'b0, 1'b1, Z, 1'b0);
        RDY1 = mo(M1, 8'd1, 1'b0, 1'b0, 1'b0, M1, 1'b0);

        // Grant latency and round-robin order 2 -> 4 -> 0 -> 1
        tbl[0]  = mv("a_req2",       mi(5'b00100, Z, Z, Z, 1'b0), NONE);
        tbl[1]  = mv("a_grant2",     mi(5'b00100, Z, Z, Z, 1'b0), mo(5'b00100, 8'd2, 1'b0, 1'b0, 1'b0, Z, 1'b0));
        tbl[2]  = mv("b_rel2",       mi(5'b10011, 5'b00100, Z, Z, 1'b0), NONE);
        tbl[3]  = mv("b_pick4",      mi(5'b10011, Z, Z, Z, 1'b0), NONE);
        tbl[4]  = mv("b_grant4",     mi(5'b10011, Z, Z, Z, 1'b0), mo(5'b10000, 8'd4, 1'b0, 1'b0, 1'b0, Z, 1'b0));
        tbl[5]  = mv("b_nonown_rel", mi(5'b10011, M0, Z, Z, 1'b0), mo(5'b10000, 8'd4, 1'b0, 1'b0, 1'b0, Z, 1'b0));
        tbl[6]  = mv("b_rel4",       mi(5'b10011, 5'b10000, Z, Z, 1'b0), NONE);
        tbl[7]  = mv("b_pick0",      mi(5'b10011, Z, Z, Z, 1'b0), NONE);
        tbl[8]  = mv("b_grant0",     mi(5'b10011, Z, Z, Z, 1'b0), mo(M0, 8'd0, 1'b0, 1'b0, 1'b0, Z, 1'b0));
        tbl[9]  = mv("b_rel_start0", mi(5'b10011, M0, M0, Z, 1'b0), NONE);
        tbl[10] = mv("b_pick1",      mi(5'b10011, Z, Z, Z, 1'b0), NONE);
        tbl[11] = mv("b_grant1",     mi(5'b10011, Z, Z, Z, 1'b0), OW1);
        tbl[12] = mv("b_nonown_st",  mi(Z, Z, M0, Z, 1'b0), OW1);
        tbl[13] = mv("b_no_send",    NOIN, OW1);

        repeat (2) @(posedge clock);
        #1;
        check("reset_state", NONE);
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i].name, tbl[i].vi, tbl[i].vo);

        // Normal command with response after DLY clocks of BUSY
        step("c_start", mi(Z, Z, M1, Z, 1'b0), OW1);
        step("c_send",  NOIN, mo(M1, 8'd1, 1'b1, 1'b0, 1'b1, Z, 1'b0));
        for (int k = 1; k < DLY; k++) step("c_wait", NOIN, BZ1);
        step("c_done",  mi(Z, Z, Z, Z, 1'b1), RDY1);
        step("c_rdy_clr", NOIN, OW1);

        // Watchdog expiry on BUSY clock TO, then late rsp_done without rsp_ready
        step("d_start", mi(Z, Z, M1, Z, 1'b0), OW1);
        step("d_send",  NOIN, mo(M1, 8'd1, 1'b1, 1'b0, 1'b1, Z, 1'b0));
        for (int k = 1; k < TO; k++) step("d_wait", NOIN, BZ1);
        step("d_timeout", NOIN, mo(M1, 8'd1, 1'b0, 1'b1, 1'b1, Z, 1'b1));
        for (int k = 0; k < 3; k++) step("d_drain", NOIN, BZ1);
        step("d_late_done", mi(Z, Z, Z, Z, 1'b1), OW1);
        step("d_no_rdy", NOIN, OW1);

        // Cancel (non-owner ignored), then DRAIN ends on its own after TO clocks
        step("e_start", mi(Z, Z, M1, Z, 1'b0), OW1);
        step("e_send",  NOIN, mo(M1, 8'd1, 1'b1, 1'b0, 1'b1, Z, 1'b0));
        step("e_nonown_cancel", mi(Z, Z, Z, M0, 1'b0), BZ1);
        step("e_cancel", mi(Z, Z, Z, M1, 1'b0), mo(M1, 8'd1, 1'b0, 1'b1, 1'b1, Z, 1'b0));
        for (int k = 1; k < TO; k++) step("e_drain", NOIN, BZ1);
        step("e_drain_expire", NOIN, OW1);

        // cancel and rsp_done together: completion wins
        step("f_start", mi(Z, Z, M1, Z, 1'b0), OW1);
        step("f_send",  NOIN, mo(M1, 8'd1, 1'b1, 1'b0, 1'b1, Z, 1'b0));
        step("f_cancel_done", mi(Z, Z, Z, M1, 1'b1), RDY1);
        step("f_nonown_start", mi(Z, Z, M0, Z, 1'b0), OW1);
        step("f_no_send", NOIN, OW1);

        // relinquish while BUSY: completes normally, then releases
        step("g_start", mi(Z, Z, M1, Z, 1'b0), OW1);
        step("g_send",  NOIN, mo(M1, 8'd1, 1'b1, 1'b0, 1'b1, Z, 1'b0));
        step("g_rel_busy", mi(Z, M1, Z, Z, 1'b0), BZ1);
        step("g_done", mi(Z, Z, Z, Z, 1'b1), RDY1);
        step("g_release", mi(Z, Z, M1, Z, 1'b0), NONE);
        step("g_no_send", NOIN, NONE);

        // Reset in the middle of BUSY acts without waiting for a clock edge
        step("h_req",   mi(M0, Z, Z, Z, 1'b0), NONE);
        step("h_grant", mi(M0, Z, Z, Z, 1'b0), mo(M0, 8'd0, 1'b0, 1'b0, 1'b0, Z, 1'b0));
        step("h_start", mi(Z, Z, M0, Z, 1'b0), mo(M0, 8'd0, 1'b0, 1'b0, 1'b0, Z, 1'b0));
        step("h_send",  NOIN, mo(M0, 8'd0, 1'b1, 1'b0, 1'b1, Z, 1'b0));
        step("h_busy",  NOIN, mo(M0, 8'd0, 1'b0, 1'b0, 1'b1, Z, 1'b0));
        #2 reset = 1'b1;
        #1 check("h_async_reset", NONE);
        @(posedge clock);
        #1;
        check("h_reset_hold", NONE);
        reset = 1'b0;
        step("h_req_all", mi(5'b11111, Z, Z, Z, 1'b0), NONE);
        step("h_first0",  mi(5'b11111, Z, Z, Z, 1'b0), mo(M0, 8'd0, 1'b0, 1'b0, 1'b0, Z, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
